mult_div_unit: RTL
==================

Name: mult_div_unit

Overview:
Iterative multiply/divide unit for the MIPS core, executing MULT, MULTU, DIV and DIVU.
- Consumes the two register-file read outputs as operands.
- Holds the architectural HI/LO registers.
- Returns MFHI/MFLO results through the register file's write port (wr/addr3/data3).
- Sits between register-file read and register-file write, alongside the ALU.

Parameters:
DATA_W, 32, operand/HI/LO width; the iteration count equals DATA_W.
RADDR_W, 5, register address width.
DIV0_LO, 32'hFFFFFFFF, quotient returned on divide-by-zero.

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  launch operation; sampled only in IDLE
op  in  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU
opnd_a  in  DATA_W  rs value (multiplicand/dividend)
opnd_b  in  DATA_W  rt value (multiplier/divisor)
busy  out  1  operation in flight
done  out  1  one-cycle pulse when HI/LO are updated
mf_req  in  1  move-from request
mf_sel  in  1  0 = HI, 1 = LO
mf_rd  in  RADDR_W  destination register
mf_stall  out  1  combinational: mf_req & busy
hi  out  DATA_W  architectural HI
lo  out  DATA_W  architectural LO
wr  out  1  register-file write enable
addr3  out  RADDR_W  register-file write address
data3  out  DATA_W  register-file write data

Behaviour:
- Reset (async, rst_n=0):
  - State IDLE.
  - busy, done, wr = 0.
  - hi, lo, addr3, data3 = 0.
  - Iteration counter = 0.
  - An in-flight operation is discarded; no done pulse follows.
- FSM states: IDLE, CALC, FIXUP.
- IDLE -> CALC: on an edge with start=1.
  - Latch op.
  - Latch |opnd_a| and |opnd_b| (signed ops) or the raw values (unsigned ops).
  - Latch the result sign:
    - MULT: sign_a ^ sign_b.
    - DIV: quotient sign sign_a ^ sign_b; remainder sign sign_a.
  - Counter = 0.
- CALC: one radix-2 step per edge, for DATA_W edges (counter 0..DATA_W-1).
  - Multiply: shift-add into a 2*DATA_W accumulator.
  - Divide: restoring shift-subtract; partial remainder is DATA_W+1 bits.
  - On the edge where counter == DATA_W-1, go to FIXUP.
- FIXUP (one edge):
  - Apply two's-complement negation per the latched signs.
  - Write hi/lo; done=1 for exactly one cycle; return to IDLE.
- Latency:
  - start sampled at edge 0; hi/lo/done update at edge DATA_W+1 (33).
  - busy is 1 for the cycles after edge 0 up to and including edge 33's preceding cycle.
  - busy falls on the same edge that done rises.
- Results:
  - Multiply: hi = product[63:32], lo = product[31:0].
  - Divide: lo = quotient (truncated toward zero), hi = remainder (sign of dividend).
- Boundary conditions:
  - Divide-by-zero (opnd_b == 0, either DIV or DIVU): still takes the full latency; hi = opnd_a, lo = DIV0_LO.
  - DIV 0x80000000 / 0xFFFFFFFF: lo = 0x80000000, hi = 0; no trap.
  - start while busy: ignored; operand inputs are ignored after edge 0.
- Move-from path:
  - On an edge with mf_req=1 & busy=0 & mf_rd != 0: next cycle wr=1, addr3=mf_rd, data3 = mf_sel ? lo : hi. wr is a one-cycle pulse.
  - mf_rd == 0: no write (wr stays 0); the request is still considered serviced.
  - mf_req while busy: no write; mf_stall=1; the requester holds mf_req until it is serviced.
  - mf_req on the done cycle: busy is already 0, so the new HI/LO values are returned.
  - mf_req and start on the same IDLE edge: mf returns the pre-operation HI/LO; the operation launches.

Decomposition:
- Shared package mdu_pkg:
  - op encodings OP_MULT/OP_MULTU/OP_DIV/OP_DIVU.
  - FSM state enum.
  - Constants DATA_W, RADDR_W, DIV0_LO.
- One sub-module, mdu_datapath:
  - Accumulator/remainder registers and the per-step shift-add/subtract.
  - Controlled by the FSM's step/load/fixup strobes.
- FSM, sign handling and the move-from path stay in mult_div_unit.

Test Plan:
- MULT opnd_a=0xFFFFFFFD (-3), opnd_b=5 -> done at edge 33; hi=0xFFFFFFFF, lo=0xFFFFFFF1; busy high for 33 cycles.
- MULTU 0xFFFFFFFF x 0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001; MFLO to r8 -> wr=1, addr3=8, data3=0x00000001 one cycle later.
- DIV 0xFFFFFFF9 (-7) / 2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF; DIV 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0.
- DIVU 100 / 0 -> hi=0x00000064, lo=0xFFFFFFFF after the full 33-edge latency.
- MFHI to r3 at edge 10 of a MULT -> mf_stall=1, wr=0 until done; serviced on the done cycle with the new hi; second start at edge 5 ignored.
- rst_n low at edge 15 of a DIVU -> immediate IDLE, busy=0, hi=lo=0, no done pulse; a new MULT 6x7 after release -> lo=42, hi=0.

Source files
------------

// File: rtl/mdu_pkg.sv
// Shared constants, op encodings and FSM states for the multiply/divide unit.
package mdu_pkg;

    localparam int          DATA_W  = 32;
    localparam int          RADDR_W = 5;
    localparam logic [31:0] DIV0_LO = 32'hFFFF_FFFF;

    typedef enum logic [1:0] {
        OP_MULT  = 2'b00,
        OP_MULTU = 2'b01,
        OP_DIV   = 2'b10,
        OP_DIVU  = 2'b11
    } mdu_op_e;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        CALC  = 2'b01,
        FIXUP = 2'b10
    } mdu_state_e;

endpackage

// File: rtl/mdu_datapath.sv
// Radix-2 iterative datapath: shift-add multiply and restoring divide on
// unsigned magnitudes. Sign correction is applied by the caller.
module mdu_datapath
    import mdu_pkg::*;
#(
    parameter int DATA_W = mdu_pkg::DATA_W
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                load_i,
    input  logic                step_i,
    input  logic                is_div_i,
    input  logic [DATA_W-1:0]   opa_i,
    input  logic [DATA_W-1:0]   opb_i,
    output logic [2*DATA_W-1:0] acc_o,
    output logic [DATA_W-1:0]   rem_o
);

    logic [DATA_W-1:0]   d_q, d_d;
    logic [2*DATA_W-1:0] acc_q, acc_d;
    logic [DATA_W-1:0]   rem_q, rem_d;
    logic [DATA_W:0]     sum, shifted, diff;

    always_comb begin
        sum     = {1'b0, acc_q[2*DATA_W-1:DATA_W]} + (acc_q[0] ? {1'b0, d_q} : '0);
        // Partial remainder is DATA_W+1 bits wide only while shifted in.
        shifted = {rem_q, acc_q[DATA_W-1]};
        diff    = shifted - {1'b0, d_q};
        d_d     = d_q;
        acc_d   = acc_q;
        rem_d   = rem_q;
        if (load_i) begin
            rem_d = '0;
            if (is_div_i) begin
                d_d   = opb_i;
                acc_d = {{DATA_W{1'b0}}, opa_i};
            end else begin
                d_d   = opa_i;
                acc_d = {{DATA_W{1'b0}}, opb_i};
            end
        end else if (step_i) begin
            if (is_div_i) begin
                if (!diff[DATA_W]) begin
                    rem_d = diff[DATA_W-1:0];
                    acc_d = {acc_q[2*DATA_W-1:DATA_W], acc_q[DATA_W-2:0], 1'b1};
                end else begin
                    rem_d = shifted[DATA_W-1:0];
                    acc_d = {acc_q[2*DATA_W-1:DATA_W], acc_q[DATA_W-2:0], 1'b0};
                end
            end else begin
                acc_d = {sum, acc_q[DATA_W-1:1]};
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            d_q   <= '0;
            acc_q <= '0;
            rem_q <= '0;
        end else begin
            d_q   <= d_d;
            acc_q <= acc_d;
            rem_q <= rem_d;
        end
    end

    assign acc_o = acc_q;
    assign rem_o = rem_q;

endmodule

// File: rtl/mult_div_unit.sv
// MIPS multiply/divide unit: FSM, sign handling, HI/LO and the MFHI/MFLO
// write-back path; the iterative arithmetic lives in mdu_datapath.
module mult_div_unit
    import mdu_pkg::*;
#(
    parameter int              DATA_W  = mdu_pkg::DATA_W,
    parameter int              RADDR_W = mdu_pkg::RADDR_W,
    parameter logic [DATA_W-1:0] DIV0_LO = mdu_pkg::DIV0_LO
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [1:0]         op,
    input  logic [DATA_W-1:0]  opnd_a,
    input  logic [DATA_W-1:0]  opnd_b,
    output logic               busy,
    output logic               done,
    input  logic               mf_req,
    input  logic               mf_sel,
    input  logic [RADDR_W-1:0] mf_rd,
    output logic               mf_stall,
    output logic [DATA_W-1:0]  hi,
    output logic [DATA_W-1:0]  lo,
    output logic               wr,
    output logic [RADDR_W-1:0] addr3,
    output logic [DATA_W-1:0]  data3
);

    localparam int CNT_W = $clog2(DATA_W);

    mdu_state_e          state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                div_q, div_d;
    logic                neg_p_q, neg_p_d;
    logic                neg_r_q, neg_r_d;
    logic                div0_q, div0_d;
    logic [DATA_W-1:0]   hi_q, hi_d, lo_q, lo_d;
    logic                done_q, done_d;
    logic                wr_q, wr_d;
    logic [RADDR_W-1:0]  addr3_q, addr3_d;
    logic [DATA_W-1:0]   data3_q, data3_d;

    logic                load, step, dp_div;
    logic                is_signed, sign_a, sign_b;
    logic [DATA_W-1:0]   mag_a, mag_b, rem;
    logic [2*DATA_W-1:0] acc;

    assign is_signed = ~op[0];
    assign sign_a    = is_signed & opnd_a[DATA_W-1];
    assign sign_b    = is_signed & opnd_b[DATA_W-1];
    assign mag_a     = sign_a ? -opnd_a : opnd_a;
    assign mag_b     = sign_b ? -opnd_b : opnd_b;
    assign dp_div    = (state_q == IDLE) ? op[1] : div_q;

    mdu_datapath #(.DATA_W(DATA_W)) u_dp (
        .clk      (clk),
        .rst_n    (rst_n),
        .load_i   (load),
        .step_i   (step),
        .is_div_i (dp_div),
        .opa_i    (mag_a),
        .opb_i    (mag_b),
        .acc_o    (acc),
        .rem_o    (rem)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        div_d   = div_q;
        neg_p_d = neg_p_q;
        neg_r_d = neg_r_q;
        div0_d  = div0_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        done_d  = 1'b0;
        load    = 1'b0;
        step    = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    load    = 1'b1;
                    state_d = CALC;
                    cnt_d   = '0;
                    div_d   = op[1];
                    neg_p_d = sign_a ^ sign_b;
                    neg_r_d = sign_a;
                    div0_d  = op[1] & (opnd_b == '0);
                end
            end
            CALC: begin
                step  = 1'b1;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_W'(DATA_W - 1)) state_d = FIXUP;
            end
            FIXUP: begin
                state_d = IDLE;
                done_d  = 1'b1;
                if (div_q) begin
                    // Remainder path already yields the dividend when dividing by zero.
                    hi_d = neg_r_q ? -rem : rem;
                    lo_d = div0_q ? DIV0_LO
                                  : (neg_p_q ? -acc[DATA_W-1:0] : acc[DATA_W-1:0]);
                end else begin
                    {hi_d, lo_d} = neg_p_q ? -acc : acc;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        wr_d    = 1'b0;
        addr3_d = addr3_q;
        data3_d = data3_q;
        if (mf_req && state_q == IDLE && mf_rd != '0) begin
            wr_d    = 1'b1;
            addr3_d = mf_rd;
            data3_d = mf_sel ? lo_q : hi_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            div_q   <= 1'b0;
            neg_p_q <= 1'b0;
            neg_r_q <= 1'b0;
            div0_q  <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
            done_q  <= 1'b0;
            wr_q    <= 1'b0;
            addr3_q <= '0;
            data3_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            div_q   <= div_d;
            neg_p_q <= neg_p_d;
            neg_r_q <= neg_r_d;
            div0_q  <= div0_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            done_q  <= done_d;
            wr_q    <= wr_d;
            addr3_q <= addr3_d;
            data3_q <= data3_d;
        end
    end

    assign busy     = (state_q != IDLE);
    assign done     = done_q;
    assign mf_stall = mf_req & busy;
    assign hi       = hi_q;
    assign lo       = lo_q;
    assign wr       = wr_q;
    assign addr3    = addr3_q;
    assign data3    = data3_q;

endmodule
